// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter.
// States, read-return tags and latency limits.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    LOAD
  } arb_state_e;

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_IF,
    TAG_DM
  } req_tag_e;

  localparam int RD_LAT_MAX = 3;

  function automatic logic tag_is_read(req_tag_e t);
    return t != TAG_NONE;
  endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Read-return tag shift register, DEPTH stages.
// Ports: clk, rst, tag_i (pushed every cycle), tag_o (oldest), empty_o.
module rd_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  req_tag_e tag_i,
  output req_tag_e tag_o,
  output logic     empty_o
);

  req_tag_e pipe_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= TAG_NONE;
      end
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

  // Empty only once the last stage has retired too, so a
  // drain waits until the final rvalid has been delivered.
  always_comb begin
    empty_o = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (tag_is_read(pipe_q[i])) begin
        empty_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port BRAM arbiter for fetch (IF), data (DM) and loader (LD).
// Ports: ld_*, if_*, dm_* requesters; mem_* macro side; busy.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int MEM_AW     = 14,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_mode,
  input  logic              ld_req,
  input  logic [31:0]       ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [31:0]       dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  arb_state_e  state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;

  req_tag_e push_tag;
  req_tag_e ret_tag;
  logic     pipe_empty;

  // State and grant decision
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    if_gnt   = 1'b0;
    dm_gnt   = 1'b0;
    ld_gnt   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (ld_mode) begin
          state_d = DRAIN;
          if (!if_req) starve_d = '0;
        end else if (if_req && dm_req) begin
          // DM normally wins; IF is forced through once it
          // has been passed over STARVE_MAX times in a row.
          if (starve_q == STARVE_TOP) begin
            if_gnt   = 1'b1;
            starve_d = '0;
          end else begin
            dm_gnt   = 1'b1;
            starve_d = starve_q + 1'b1;
          end
        end else begin
          if_gnt   = if_req;
          dm_gnt   = dm_req;
          starve_d = '0;
        end
      end
      DRAIN: begin
        if (!if_req) starve_d = '0;
        if (!ld_mode) begin
          state_d = RUN;
        end else if (pipe_empty) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (!if_req) starve_d = '0;
        // A write arriving as ld_mode falls is still taken.
        ld_gnt = ld_req;
        if (!ld_mode && !ld_req) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Memory-side mux: grants are mutually exclusive.
  always_comb begin
    mem_en    = if_gnt | dm_gnt | ld_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    push_tag  = TAG_NONE;
    unique case (1'b1)
      ld_gnt: begin
        mem_we    = 1'b1;
        mem_addr  = ld_addr[MEM_AW+1:2];
        mem_wdata = ld_wdata;
      end
      dm_gnt: begin
        mem_we    = dm_we;
        mem_addr  = dm_addr[MEM_AW+1:2];
        mem_wdata = dm_wdata;
        push_tag  = dm_we ? TAG_NONE : TAG_DM;
      end
      if_gnt: begin
        mem_addr = if_addr[MEM_AW+1:2];
        push_tag = TAG_IF;
      end
      default: begin
        mem_en = 1'b0;
      end
    endcase
  end

  rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_i   (push_tag),
    .tag_o   (ret_tag),
    .empty_o (pipe_empty)
  );

  // Read data is shared; consumers qualify it with rvalid.
  assign if_rvalid = (ret_tag == TAG_IF);
  assign dm_rvalid = (ret_tag == TAG_DM);
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;

  assign busy = (state_q == DRAIN) || (state_q == LOAD);

  // Byte-lane and high address bits are not decoded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:MEM_AW+2], if_addr[1:0],
                              dm_addr[31:MEM_AW+2], dm_addr[1:0],
                              ld_addr[31:MEM_AW+2], ld_addr[1:0]};

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous data/instruction BRAM between three requesters: pipeline instruction fetch (IF), pipeline data access (DM), and the program loader (LD).
- Sits between riscv_pipeline's instruction/data memory ports and the memory macro.
- Grants at most one access per cycle and routes read data back with a fixed read latency.
- Supplies per-requester grants; the hazard unit uses a missing grant as a stall.

Parameters:
- DATA_W, 32, data width of every port.
- MEM_AW, 14, word-address width of the memory macro.
- RD_LAT, 1, memory read latency in cycles; legal range 1..3.
- STARVE_MAX, 4, consecutive cycles IF may be refused in favour of DM before IF is forced to win.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ld_mode  in  1  level; high requests loader ownership of the memory.
- ld_req  in  1  loader write request.
- ld_addr  in  32  loader byte address.
- ld_wdata  in  DATA_W  loader write data.
- ld_gnt  out  1  loader write accepted this cycle.
- if_req  in  1  fetch read request.
- if_addr  in  32  fetch byte address (pc).
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  DATA_W  fetch read data.
- dm_req  in  1  data request.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  32  data byte address.
- dm_wdata  in  DATA_W  data write value.
- dm_gnt  out  1  data request accepted this cycle.
- dm_rvalid  out  1  data read valid.
- dm_rdata  out  DATA_W  data read value.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  MEM_AW  memory word address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after the enable.
- busy  out  1  high in DRAIN or LOAD.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. On reset the state is RUN, starve_cnt = 0, the in-flight tag pipe is cleared, and all registered outputs are 0. Reads in flight when reset asserts are dropped and never produce an rvalid.
- Grants are combinational from the requests and the current state. A request is accepted in the cycle its gnt is high. A requester holds req and its operands stable until granted.
- mem_en is high exactly when some gnt is high. mem_addr = winner byte address [MEM_AW+1:2]; bits [1:0] are ignored. mem_we = granted write (LD always writes; DM writes when dm_we is high).
- FSM state RUN:
  - ld_mode = 1: no grants; go to DRAIN.
  - Otherwise, if if_req && dm_req && starve_cnt == STARVE_MAX, IF wins.
  - Otherwise DM wins over IF.
  - starve_cnt increments, saturating, when IF requests and is refused in favour of DM. It clears when IF is granted or does not request.
- FSM state DRAIN: no grants. Go to LOAD when the tag pipe is empty. Return to RUN if ld_mode has dropped.
- FSM state LOAD: ld_gnt = ld_req; IF and DM are never granted. When ld_mode = 0 and ld_req = 0, go to RUN the next cycle. A ld_req arriving in the same cycle ld_mode falls is still granted.
- Read return:
  - Each granted read pushes tag IF or DM into an RD_LAT-deep shift pipe; writes push NONE.
  - At pipe output: if_rvalid / dm_rvalid = (tag == IF / DM).
  - if_rdata and dm_rdata both carry mem_rdata (combinational route); consumers qualify them with rvalid.
  - Exactly one rvalid per granted read, in request order. Throughput is 1 access per cycle.
- A DM write and an IF read of the same address in consecutive cycles: the read returns the new data (BRAM write-first). Memory configuration must guarantee this; the arbiter adds no bypass.

Decomposition:
- mem_arb_pkg holds:
  - typedef enum arb_state_e {RUN, DRAIN, LOAD};
  - typedef enum logic [1:0] req_tag_e {TAG_NONE, TAG_IF, TAG_DM};
  - localparam RD_LAT_MAX = 3.
- Sub-module rd_tag_pipe: parameterised RD_LAT-deep tag shift register with an empty flag, reused for later cache refill.

Test Plan:
- Reset, then if_req=1, if_addr=0x10 alone, RD_LAT=1 -> if_gnt=1 same cycle, mem_addr=4, if_rvalid=1 next cycle with mem_rdata.
- if_req and dm_req both held high for 6 cycles, dm_we=0, STARVE_MAX=4 -> DM granted cycles 0-3, IF granted cycle 4, DM cycle 5. rvalid tags return in the same order.
- DM write 0xDEADBEEF to 0x100, then IF read 0x100 -> mem_we=1 then mem_en read; if_rdata = 0xDEADBEEF one cycle later.
- DM read granted, ld_mode rises the same cycle, RD_LAT=3 -> FSM in DRAIN for 3 cycles with no grants, dm_rvalid fires, then LOAD; ld_req writes granted every cycle.
- In LOAD, ld_mode=0 with ld_req=1 -> that write is granted; RUN follows with ld_req=0; busy drops.
- Two reads in flight with RD_LAT=2, rst asserted -> no rvalid afterwards, all outputs 0, state RUN.
